// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 2x2 convolution scheduler and its valid tracker.
//   PIX_W        : IFM pixel / weight width
//   OFM_W        : datapath result width (4*15*15 = 900 fits, no saturation)
//   PIPE_STAGES  : register stages in the convolution datapath
//   ST_*         : scheduler FSM state encodings
//   num_windows  : stride-1 2x2 window count for a tile
// ---------------------------------------------------------------------------
package conv_pkg;

   localparam int PIX_W       = 4;
   localparam int OFM_W       = 12;
   localparam int PIPE_STAGES = 4;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LOAD    = 3'd1;
   localparam state_t ST_COMPUTE = 3'd2;
   localparam state_t ST_FLUSH   = 3'd3;
   localparam state_t ST_DONE    = 3'd4;

   function automatic int num_windows(input int w, input int h);
      return (w - 1) * (h - 1);
   endfunction

endpackage

// File: rtl/conv_vld_tracker.sv
// ---------------------------------------------------------------------------
// conv_vld_tracker
// Tracks which datapath register stages hold real data and derives the
// datapath advance strobe and the result handshake.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_issue       : a real window is offered this cycle (COMPUTE)
//   i_flush       : draining the pipe with don't-care pixels (FLUSH)
//   i_ofm_ready   : consumer accepts the presented result
//   o_adv         : datapath advance (conv_in_valid)
//   o_hs          : result handshake this cycle
//   o_vld         : per-stage valid; bit 0 input regs .. top bit conv_ofm
// ---------------------------------------------------------------------------
module conv_vld_tracker
   import conv_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_issue,
   input  logic                   i_flush,
   input  logic                   i_ofm_ready,
   output logic                   o_adv,
   output logic                   o_hs,
   output logic [PIPE_STAGES-1:0] o_vld
);

   logic [PIPE_STAGES-1:0] r_vld;
   logic                   w_front_busy;
   logic                   w_out_free;

   assign w_front_busy = |r_vld[PIPE_STAGES-2:0];
   // The output register may be overwritten only if it is empty or being
   // consumed this very cycle; otherwise the whole pipe freezes.
   assign w_out_free   = !r_vld[PIPE_STAGES-1] || i_ofm_ready;
   // Flushing only advances while something real is still upstream, so the
   // datapath never toggles on pure bubbles.
   assign o_adv = w_out_free && (i_issue || (i_flush && w_front_busy));
   assign o_hs  = r_vld[PIPE_STAGES-1] && i_ofm_ready;
   assign o_vld = r_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
      end else if (o_adv) begin
         r_vld <= {r_vld[PIPE_STAGES-2:0], i_issue};
      end else if (o_hs) begin
         r_vld[PIPE_STAGES-1] <= 1'b0;
      end
   end

endmodule

// File: rtl/conv2x2_scheduler.sv
// ---------------------------------------------------------------------------
// conv2x2_scheduler
// Buffers one IFM tile, latches one 2x2 kernel and issues every stride-1
// window to an external 4-stage convolution datapath, returning results over
// a valid/ready handshake.
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : begin a job (sampled in IDLE only)
//   w_1..w_4              : kernel weights, latched on an accepted start
//   pix_valid, pix_data   : raster-order IFM pixel stream
//   pix_ready             : high in LOAD
//   conv_in_valid         : datapath advance strobe
//   conv_ifm_1..4         : window pixels TL, TR, BL, BR
//   conv_w_1..4           : latched weights
//   conv_ofm              : datapath result register
//   ofm_valid/data/last   : result presentation, last = final window
//   ofm_ready             : consumer accepts result
//   busy                  : state is not IDLE
//   done                  : one-cycle pulse at job end
// ---------------------------------------------------------------------------
module conv2x2_scheduler
   import conv_pkg::*;
#(
   parameter int IFM_W = 8,
   parameter int IFM_H = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [PIX_W-1:0] w_1,
   input  logic [PIX_W-1:0] w_2,
   input  logic [PIX_W-1:0] w_3,
   input  logic [PIX_W-1:0] w_4,
   input  logic             pix_valid,
   input  logic [PIX_W-1:0] pix_data,
   output logic             pix_ready,
   output logic             conv_in_valid,
   output logic [PIX_W-1:0] conv_ifm_1,
   output logic [PIX_W-1:0] conv_ifm_2,
   output logic [PIX_W-1:0] conv_ifm_3,
   output logic [PIX_W-1:0] conv_ifm_4,
   output logic [PIX_W-1:0] conv_w_1,
   output logic [PIX_W-1:0] conv_w_2,
   output logic [PIX_W-1:0] conv_w_3,
   output logic [PIX_W-1:0] conv_w_4,
   input  logic [OFM_W-1:0] conv_ofm,
   output logic             ofm_valid,
   output logic [OFM_W-1:0] ofm_data,
   output logic             ofm_last,
   input  logic             ofm_ready,
   output logic             busy,
   output logic             done
);

   localparam int NPIX = IFM_W * IFM_H;
   localparam int NWIN = num_windows(IFM_W, IFM_H);
   localparam int PCW  = $clog2(NPIX + 1);
   localparam int AW   = $clog2(NPIX);
   localparam int RW   = $clog2(IFM_H);
   localparam int CW   = $clog2(IFM_W);
   localparam int RCW  = $clog2(NWIN + 1);

   localparam logic [AW-1:0] ROW_STEP = AW'(IFM_W);

   state_t           r_state;
   logic [PCW-1:0]   r_pix_cnt;
   logic [RW-1:0]    r_row;
   logic [CW-1:0]    r_col;
   logic [RCW-1:0]   r_res_cnt;
   logic [PIX_W-1:0] r_w1;
   logic [PIX_W-1:0] r_w2;
   logic [PIX_W-1:0] r_w3;
   logic [PIX_W-1:0] r_w4;
   logic [PIX_W-1:0] r_ifm [0:NPIX-1];

   logic                   w_pix_acc;
   logic                   w_last_pix;
   logic                   w_last_win;
   logic                   w_last_col;
   logic                   w_issue;
   logic                   w_flush;
   logic                   w_win_en;
   logic                   w_adv;
   logic                   w_hs;
   logic [PIPE_STAGES-1:0] w_vld;
   logic [AW-1:0]          w_idx_tl;
   logic [AW-1:0]          w_idx_tr;
   logic [AW-1:0]          w_idx_bl;
   logic [AW-1:0]          w_idx_br;

   assign w_pix_acc  = (r_state == ST_LOAD) && pix_valid;
   assign w_last_pix = (r_pix_cnt == PCW'(NPIX - 1));
   assign w_last_col = (r_col == CW'(IFM_W - 2));
   assign w_last_win = w_last_col && (r_row == RW'(IFM_H - 2));
   assign w_issue    = (r_state == ST_COMPUTE);
   assign w_flush    = (r_state == ST_FLUSH);
   assign w_win_en   = w_issue || w_flush;

   conv_vld_tracker u_vld (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_issue     (w_issue),
      .i_flush     (w_flush),
      .i_ofm_ready (ofm_ready),
      .o_adv       (w_adv),
      .o_hs        (w_hs),
      .o_vld       (w_vld)
   );

   // Window addresses. The row/col counters stop on the last window, so the
   // FLUSH phase keeps presenting those pixels and the datapath inputs stay
   // quiet while the pipe drains.
   assign w_idx_tl = AW'(r_row) * ROW_STEP + AW'(r_col);
   assign w_idx_tr = w_idx_tl + AW'(1);
   assign w_idx_bl = w_idx_tl + ROW_STEP;
   assign w_idx_br = w_idx_bl + AW'(1);

   // Pixels are forced to zero outside COMPUTE/FLUSH so the outputs have a
   // defined value even though the tile buffer itself is never reset.
   assign conv_ifm_1 = w_win_en ? r_ifm[w_idx_tl] : '0;
   assign conv_ifm_2 = w_win_en ? r_ifm[w_idx_tr] : '0;
   assign conv_ifm_3 = w_win_en ? r_ifm[w_idx_bl] : '0;
   assign conv_ifm_4 = w_win_en ? r_ifm[w_idx_br] : '0;

   assign conv_w_1 = r_w1;
   assign conv_w_2 = r_w2;
   assign conv_w_3 = r_w3;
   assign conv_w_4 = r_w4;

   assign conv_in_valid = w_adv;
   assign pix_ready     = (r_state == ST_LOAD);
   assign busy          = (r_state != ST_IDLE);
   assign done          = (r_state == ST_DONE);
   assign ofm_valid     = w_vld[PIPE_STAGES-1];
   assign ofm_data      = conv_ofm;
   assign ofm_last      = ofm_valid && (r_res_cnt == RCW'(NWIN - 1));

   // Tile buffer: pure data storage, written in raster order during LOAD.
   always_ff @(posedge clk) begin
      if (w_pix_acc) begin
         r_ifm[r_pix_cnt[AW-1:0]] <= pix_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_pix_cnt <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_res_cnt <= '0;
         r_w1      <= '0;
         r_w2      <= '0;
         r_w3      <= '0;
         r_w4      <= '0;
      end else begin
         if (w_hs) begin
            r_res_cnt <= r_res_cnt + 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state   <= ST_LOAD;
                  r_w1      <= w_1;
                  r_w2      <= w_2;
                  r_w3      <= w_3;
                  r_w4      <= w_4;
                  r_pix_cnt <= '0;
                  r_row     <= '0;
                  r_col     <= '0;
                  r_res_cnt <= '0;
               end
            end
            ST_LOAD: begin
               if (pix_valid) begin
                  r_pix_cnt <= r_pix_cnt + 1'b1;
                  if (w_last_pix) begin
                     r_state <= ST_COMPUTE;
                  end
               end
            end
            ST_COMPUTE: begin
               if (w_adv) begin
                  if (w_last_win) begin
                     r_state <= ST_FLUSH;
                  end else if (w_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + 1'b1;
                  end else begin
                     r_col <= r_col + 1'b1;
                  end
               end
            end
            ST_FLUSH: begin
               // Once nothing is upstream, the presented result is the last
               // window; leaving needs its handshake.
               if ((w_vld[PIPE_STAGES-2:0] == '0) && w_hs) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv2x2_scheduler.sv
module tb_conv2x2_scheduler;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int NPIX = W * H;
   localparam int NWIN = (W - 1) * (H - 1);

   typedef struct {
      int mode;        // 0 all ones, 1 all 15, 2 ramp
      int w1;
      int w2;
      int w3;
      int w4;
      int ready_pct;
      bit extras;      // pixel gaps, start pulses, 65th pixel, weight scramble
      int abort_at;    // reset after this many results, -1 = never
      int exp_first;
      int exp_second;
      int exp_done;    // cycles from start acceptance to done, -1 = skip
   } job_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  w_1 = 4'd0;
   logic [3:0]  w_2 = 4'd0;
   logic [3:0]  w_3 = 4'd0;
   logic [3:0]  w_4 = 4'd0;
   logic        pix_valid = 1'b0;
   logic [3:0]  pix_data = 4'd0;
   logic        pix_ready;
   logic        conv_in_valid;
   logic [3:0]  conv_ifm_1, conv_ifm_2, conv_ifm_3, conv_ifm_4;
   logic [3:0]  conv_w_1, conv_w_2, conv_w_3, conv_w_4;
   logic [11:0] conv_ofm;
   logic        ofm_valid;
   logic [11:0] ofm_data;
   logic        ofm_last;
   logic        ofm_ready = 1'b0;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;
   int tb_cyc = 0;
   int res_idx = 0;
   bit mon_en = 1'b0;
   int cur_first = 0;
   int cur_second = 0;
   int img [NPIX];
   int cw1 = 0, cw2 = 0, cw3 = 0, cw4 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   conv2x2_scheduler #(.IFM_W(W), .IFM_H(H)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .w_1           (w_1),
      .w_2           (w_2),
      .w_3           (w_3),
      .w_4           (w_4),
      .pix_valid     (pix_valid),
      .pix_data      (pix_data),
      .pix_ready     (pix_ready),
      .conv_in_valid (conv_in_valid),
      .conv_ifm_1    (conv_ifm_1),
      .conv_ifm_2    (conv_ifm_2),
      .conv_ifm_3    (conv_ifm_3),
      .conv_ifm_4    (conv_ifm_4),
      .conv_w_1      (conv_w_1),
      .conv_w_2      (conv_w_2),
      .conv_w_3      (conv_w_3),
      .conv_w_4      (conv_w_4),
      .conv_ofm      (conv_ofm),
      .ofm_valid     (ofm_valid),
      .ofm_data      (ofm_data),
      .ofm_last      (ofm_last),
      .ofm_ready     (ofm_ready),
      .busy          (busy),
      .done          (done)
   );

   // Four-stage convolution datapath that advances only on conv_in_valid.
   logic [3:0]  d_i1, d_i2, d_i3, d_i4, d_w1, d_w2, d_w3, d_w4;
   logic [11:0] d_p1, d_p2, d_p3, d_p4, d_s1, d_s2, d_ofm;

   always @(posedge clk) begin
      if (conv_in_valid) begin
         d_i1  <= conv_ifm_1;
         d_i2  <= conv_ifm_2;
         d_i3  <= conv_ifm_3;
         d_i4  <= conv_ifm_4;
         d_w1  <= conv_w_1;
         d_w2  <= conv_w_2;
         d_w3  <= conv_w_3;
         d_w4  <= conv_w_4;
         d_p1  <= 12'(d_i1) * 12'(d_w1);
         d_p2  <= 12'(d_i2) * 12'(d_w2);
         d_p3  <= 12'(d_i3) * 12'(d_w3);
         d_p4  <= 12'(d_i4) * 12'(d_w4);
         d_s1  <= d_p1 + d_p2;
         d_s2  <= d_p3 + d_p4;
         d_ofm <= d_s1 + d_s2;
      end
   end
   assign conv_ofm = d_ofm;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int win_ref(input int k);
      int r, c;
      r = k / (W - 1);
      c = k % (W - 1);
      return cw1 * img[r*W + c] + cw2 * img[r*W + c + 1]
           + cw3 * img[(r+1)*W + c] + cw4 * img[(r+1)*W + c + 1];
   endfunction

   // Result monitor: sampled on the falling edge, between active edges.
   initial begin
      bit          was_stall;
      logic [11:0] held;
      was_stall = 1'b0;
      held      = '0;
      forever begin
         @(negedge clk);
         if (!mon_en || !rst_n) begin
            was_stall = 1'b0;
         end else begin
            if (was_stall && ofm_valid) chk("stall_hold", int'(ofm_data), int'(held));
            was_stall = 1'b0;
            if (conv_in_valid) chk("adv_busy", int'(busy), 1);
            if (ofm_valid && !ofm_ready) begin
               chk("stall_no_adv", int'(conv_in_valid), 0);
               was_stall = 1'b1;
               held      = ofm_data;
            end else if (ofm_valid) begin
               if (res_idx == 0) chk("first_win", int'(ofm_data), cur_first);
               if (res_idx == 1) chk("second_win", int'(ofm_data), cur_second);
               if (res_idx < NWIN) chk("res_data", int'(ofm_data), win_ref(res_idx));
               else chk("res_extra", res_idx, NWIN - 1);
               chk("res_last", int'(ofm_last), int'(res_idx == NWIN - 1));
               res_idx++;
            end
         end
      end
   end

   task automatic run_job(input job_t j);
      int s_cyc;
      int first_vld;
      bit gap;
      bit got;
      for (int i = 0; i < NPIX; i++) begin
         case (j.mode)
            0:       img[i] = 1;
            1:       img[i] = 15;
            default: img[i] = ((i / W) * 8 + (i % W)) % 16;
         endcase
      end
      cw1 = j.w1; cw2 = j.w2; cw3 = j.w3; cw4 = j.w4;
      cur_first  = j.exp_first;
      cur_second = j.exp_second;
      res_idx    = 0;
      first_vld  = -1;
      gap        = 1'b0;
      got        = 1'b0;

      @(posedge clk); #1;
      start = 1'b1;
      w_1 = 4'(j.w1); w_2 = 4'(j.w2); w_3 = 4'(j.w3); w_4 = 4'(j.w4);
      @(posedge clk); #1;
      s_cyc  = tb_cyc;
      start  = 1'b0;
      mon_en = 1'b1;
      chk("load_ready", int'(pix_ready), 1);
      chk("load_busy", int'(busy), 1);
      if (j.extras) begin
         w_1 = 4'd7; w_2 = 4'd7; w_3 = 4'd7; w_4 = 4'd7;
      end

      for (int i = 0; i < NPIX; ) begin
         if (j.extras && (i % 3 == 2) && !gap) begin
            pix_valid = 1'b0;
            gap       = 1'b1;
         end else begin
            pix_valid = 1'b1;
            pix_data  = 4'(img[i]);
            gap       = 1'b0;
            i++;
         end
         start = j.extras && (i == 10);
         @(posedge clk); #1;
      end

      // A 65th pixel (extras only) is offered while the block computes.
      pix_valid = j.extras;
      pix_data  = 4'hF;
      start     = 1'b0;
      chk("pix_ready_off", int'(pix_ready), 0);
      chk("w_latched", int'(conv_w_1), j.w1);

      for (int n = 0; n < 4000; n++) begin
         ofm_ready = ($urandom_range(0, 99) < j.ready_pct);
         start     = j.extras && (res_idx < NWIN);
         @(posedge clk); #1;
         pix_valid = 1'b0;
         if (first_vld < 0 && ofm_valid) first_vld = tb_cyc - s_cyc;
         if (j.abort_at >= 0 && res_idx >= j.abort_at) begin
            mon_en    = 1'b0;
            ofm_ready = 1'b0;
            start     = 1'b0;
            rst_n     = 1'b0;
            #1;
            chk("rst_pix_ready", int'(pix_ready), 0);
            chk("rst_in_valid", int'(conv_in_valid), 0);
            chk("rst_ofm_valid", int'(ofm_valid), 0);
            chk("rst_ofm_last", int'(ofm_last), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_done", int'(done), 0);
            chk("rst_ifm", int'({conv_ifm_1, conv_ifm_2, conv_ifm_3, conv_ifm_4}), 0);
            chk("rst_w", int'({conv_w_1, conv_w_2, conv_w_3, conv_w_4}), 0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         if (done) begin
            got = 1'b1;
            break;
         end
      end

      start     = 1'b0;
      ofm_ready = 1'b0;
      chk("done_seen", int'(got), 1);
      chk("res_count", res_idx, NWIN);
      if (j.exp_done >= 0) begin
         chk("done_latency", tb_cyc - s_cyc, j.exp_done);
         chk("first_latency", first_vld, 68);
      end
      @(posedge clk); #1;
      chk("done_pulse", int'(done), 0);
      chk("idle_busy", int'(busy), 0);
      mon_en = 1'b0;
   endtask

   initial begin
      job_t jobs [7];
      //          mode w1 w2 w3 w4 rdy ext  abort first second done
      jobs[0] = '{0,   1, 1, 1, 1, 100, 1'b0, -1,   4,   4,   117};
      jobs[1] = '{1,  15,15,15,15, 100, 1'b0, -1, 900, 900,   117};
      jobs[2] = '{2,   1, 2, 3, 4, 100, 1'b0, -1,  62,  72,   117};
      jobs[3] = '{2,   1, 2, 3, 4,  30, 1'b0, -1,  62,  72,    -1};
      jobs[4] = '{2,   1, 2, 3, 4, 100, 1'b0, 20,  62,  72,    -1};
      jobs[5] = '{2,   4, 3, 2, 1, 100, 1'b0, -1,  28,  38,   117};
      jobs[6] = '{2,   1, 2, 3, 4,  50, 1'b1, -1,  62,  72,    -1};

      rst_n = 1'b0;
      #2;
      chk("init_pix_ready", int'(pix_ready), 0);
      chk("init_in_valid", int'(conv_in_valid), 0);
      chk("init_ofm_valid", int'(ofm_valid), 0);
      chk("init_ofm_last", int'(ofm_last), 0);
      chk("init_busy", int'(busy), 0);
      chk("init_done", int'(done), 0);
      chk("init_ifm", int'({conv_ifm_1, conv_ifm_2, conv_ifm_3, conv_ifm_4}), 0);
      chk("init_w", int'({conv_w_1, conv_w_2, conv_w_3, conv_w_4}), 0);
      #20;
      @(posedge clk); #1;
      rst_n = 1'b1;

      for (int k = 0; k < 7; k++) run_job(jobs[k]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
